gdp_net_seq: RTL and testbench
==============================

# gdp_net_seq

Sequencer that drives one `gdp_net` CNN core from a host-side pixel stream. It accepts one 784-pixel image per inference over a valid/ready stream and replays it to the core as a contiguous `store` burst. It then issues `start`, captures `categories` on `one_end`, and returns the class over a valid/ready result port. It soft-resets the core between images and reports underrun and timeout faults. It sits between the host/DMA interface and `gdp_net`.

## Interface
Parameters:
- `N_PIX`, 784: pixels per image.
- `PIX_W`, 16: signed pixel width.
- `CLS_W`, 4: class width.
- `RST_CYC`, 2: cycles `net_rst_n` is held low in RECOVER (≥1).
- `TIMEOUT`, 200000: max cycles allowed in WAIT_STORE or RUN.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `pix_valid`, in, 1: host pixel valid.
- `pix_ready`, out, 1: pixel accepted when `pix_valid & pix_ready`.
- `pix_data`, in, PIX_W: signed pixel.
- `res_valid`, out, 1: class available.
- `res_ready`, in, 1: host accepts the class.
- `res_class`, out, CLS_W: captured class.
- `busy`, out, 1: state ≠ IDLE.
- `err_underrun`, out, 1: sticky; pixel gap during LOAD.
- `err_timeout`, out, 1: sticky; core did not respond in time.
- `err_clr`, in, 1: clears both sticky errors.
- `img_count`, out, 16: completed results; wraps.
- `net_rst_n`, out, 1: core reset.
- `net_store`, out, 1: core store.
- `net_pixel`, out, PIX_W: core image_pixel.
- `net_store_finish`, in, 1: core store_finish.
- `net_start`, out, 1: core start.
- `net_one_end`, in, 1: core one_end.
- `net_categories`, in, CLS_W: core categories.

## Operation
- States: IDLE, LOAD, WAIT_STORE, RUN, RESULT, RECOVER. All net-side outputs are registered.
- IDLE: `pix_ready=0`. Enter LOAD when `pix_valid=1`.
- LOAD: `pix_ready=1`.
  - Each accepted pixel registers into `net_pixel` and increments `pix_cnt`.
  - `net_store=1` for every cycle a pixel is presented.
  - On the N_PIX-th accept, go to WAIT_STORE.
  - If `pix_valid=0` with `pix_cnt` in 1..N_PIX-1: set `err_underrun`, `net_store<=0`, go to RECOVER. The partial image is discarded.
- WAIT_STORE: `net_store` held 1, `pix_ready=0`.
  - On `net_store_finish=1`: `net_store<=0`, `net_start<=1`, go to RUN.
- RUN: `net_start` held 1.
  - On `net_one_end=1`: `res_class<=net_categories`, `res_valid<=1`, `net_start<=0`, go to RESULT.
- Timeout counter (width `$clog2(TIMEOUT+1)`):
  - Cleared on entry to WAIT_STORE and to RUN; increments each cycle in those states.
  - On reaching TIMEOUT: set `err_timeout`, drop `net_store`/`net_start`, go to RECOVER.
  - `net_store_finish`/`net_one_end` in the same cycle as the terminal count wins over the timeout.
- RESULT: hold `res_valid`/`res_class` until `res_ready`. On handshake: `res_valid<=0`, `img_count+=1`, go to RECOVER.
- RECOVER: `net_rst_n=0` for exactly RST_CYC cycles; `net_store=net_start=0`. Then `net_rst_n<=1`, go to IDLE. `pix_cnt` is cleared.
- `err_clr` clears the sticky errors in any state. A same-cycle error set wins over `err_clr`.
- `busy` is combinational from state.

## Timing
- Reset values:
  - State IDLE.
  - `net_rst_n=0` while `n_reset=0`; 1 on the first edge after release.
  - All other outputs 0; `net_pixel=0`, `res_class=0`, `img_count=0`.
- Pixel accepted at edge k appears on `net_pixel` at edge k+1, together with `net_store=1`.
- `net_start` rises at edge +1 after `net_store_finish` is sampled.
- `res_valid` rises at edge +1 after `net_one_end` is sampled.
- Minimum image period: N_PIX + 1 (IDLE) + 1 (WAIT_STORE, if finish is immediate) + RUN + 1 (RESULT) + RST_CYC.
- Reset mid-operation: asserting `n_reset` at any time immediately forces IDLE and the reset values, and asserts `net_rst_n=0`.
- `net_store_finish`/`net_one_end` are ignored outside WAIT_STORE/RUN.

## Test plan
- Nominal: stream 784 pixels (0..783), behavioural core asserts finish 3 cycles later and `one_end` after 50 cycles with categories=7 → `net_pixel` reproduces 0..783 one per cycle; `res_class=7`; `img_count=1`; `net_rst_n` low for 2 cycles; returns to IDLE.
- Back-pressure: hold `res_ready=0` for 20 cycles → `res_valid` and `res_class` stable; no RECOVER until the handshake.
- Underrun: drop `pix_valid` after pixel 100 → `err_underrun=1`; `net_store` falls; RECOVER; no result. `err_clr` → flag 0.
- Timeout: TIMEOUT=64, core never asserts `one_end` → `err_timeout=1` after 64 RUN cycles; `net_start=0`; RECOVER; `img_count` unchanged.
- Back-to-back: three images with classes 3, 9, 0 and continuous `res_ready` → three results in order; `img_count=3`.
- Reset mid-LOAD at pixel 400 → all outputs at reset values; the next full image completes normally.

Source files
------------

// File: rtl/gdp_net_seq.sv
// Host-side sequencer for one gdp_net core: buffers nothing, replays a pixel
// stream as a store burst, runs the core, and returns the class with fault flags.
module gdp_net_seq #(
  parameter int N_PIX   = 784,
  parameter int PIX_W   = 16,
  parameter int CLS_W   = 4,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 200000
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic signed [PIX_W-1:0] pix_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic        [CLS_W-1:0] res_class,
  output logic                    busy,
  output logic                    err_underrun,
  output logic                    err_timeout,
  input  logic                    err_clr,
  output logic             [15:0] img_count,
  output logic                    net_rst_n,
  output logic                    net_store,
  output logic signed [PIX_W-1:0] net_pixel,
  input  logic                    net_store_finish,
  output logic                    net_start,
  input  logic                    net_one_end,
  input  logic        [CLS_W-1:0] net_categories
);

  localparam int CNT_W = $clog2(N_PIX + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RCW   = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_RUN, S_RESULT, S_RECOVER
  } state_e;

  state_e state_q, state_d;

  logic        [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic        [TMO_W-1:0] tmo_q, tmo_d;
  logic          [RCW-1:0] rcnt_q, rcnt_d;
  logic                    net_rst_n_q, net_rst_n_d;
  logic                    net_store_q, net_store_d;
  logic                    net_start_q, net_start_d;
  logic signed [PIX_W-1:0] net_pixel_q, net_pixel_d;
  logic                    res_valid_q, res_valid_d;
  logic        [CLS_W-1:0] res_class_q, res_class_d;
  logic             [15:0] img_count_q, img_count_d;
  logic                    err_und_q, err_und_d;
  logic                    err_tmo_q, err_tmo_d;
  logic                    und_set, tmo_set;

  logic last_pix, tmo_last, rcnt_last;

  assign last_pix  = (pix_cnt_q == CNT_W'(N_PIX - 1));
  // The response cycle that would make the count reach TIMEOUT still wins.
  assign tmo_last  = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign rcnt_last = (rcnt_q == RCW'(RST_CYC - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pix_valid) state_d = S_LOAD;
      S_LOAD: begin
        if (pix_valid && last_pix)                    state_d = S_WAIT;
        else if (!pix_valid && pix_cnt_q != '0)       state_d = S_RECOVER;
      end
      S_WAIT: begin
        if (net_store_finish) state_d = S_RUN;
        else if (tmo_last)    state_d = S_RECOVER;
      end
      S_RUN: begin
        if (net_one_end)   state_d = S_RESULT;
        else if (tmo_last) state_d = S_RECOVER;
      end
      S_RESULT:  if (res_ready) state_d = S_RECOVER;
      S_RECOVER: if (rcnt_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    tmo_d       = tmo_q;
    rcnt_d      = rcnt_q;
    net_rst_n_d = net_rst_n_q;
    net_store_d = net_store_q;
    net_start_d = net_start_q;
    net_pixel_d = net_pixel_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    img_count_d = img_count_q;
    und_set     = 1'b0;
    tmo_set     = 1'b0;
    case (state_q)
      S_IDLE: begin
        net_rst_n_d = 1'b1;
        net_store_d = 1'b0;
        net_start_d = 1'b0;
        pix_cnt_d   = '0;
      end
      S_LOAD: begin
        net_store_d = pix_valid;
        if (pix_valid) begin
          net_pixel_d = pix_data;
          pix_cnt_d   = pix_cnt_q + CNT_W'(1);
          tmo_d       = '0;
        end else if (pix_cnt_q != '0) begin
          und_set     = 1'b1;
          rcnt_d      = '0;
          net_rst_n_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (net_store_finish) begin
          net_store_d = 1'b0;
          net_start_d = 1'b1;
          tmo_d       = '0;
        end else if (tmo_last) begin
          tmo_set     = 1'b1;
          net_store_d = 1'b0;
          rcnt_d      = '0;
          net_rst_n_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RUN: begin
        if (net_one_end) begin
          res_class_d = net_categories;
          res_valid_d = 1'b1;
          net_start_d = 1'b0;
        end else if (tmo_last) begin
          tmo_set     = 1'b1;
          net_start_d = 1'b0;
          rcnt_d      = '0;
          net_rst_n_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          img_count_d = img_count_q + 16'd1;
          rcnt_d      = '0;
          net_rst_n_d = 1'b0;
        end
      end
      S_RECOVER: begin
        net_store_d = 1'b0;
        net_start_d = 1'b0;
        pix_cnt_d   = '0;
        if (rcnt_last) net_rst_n_d = 1'b1;
        else           rcnt_d      = rcnt_q + RCW'(1);
      end
      default: ;
    endcase
    // A fault raised this cycle survives a simultaneous clear.
    err_und_d = und_set | (err_und_q & ~err_clr);
    err_tmo_d = tmo_set | (err_tmo_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pix_cnt_q   <= '0;
      tmo_q       <= '0;
      rcnt_q      <= '0;
      net_rst_n_q <= 1'b0;
      net_store_q <= 1'b0;
      net_start_q <= 1'b0;
      net_pixel_q <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      img_count_q <= '0;
      err_und_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      tmo_q       <= tmo_d;
      rcnt_q      <= rcnt_d;
      net_rst_n_q <= net_rst_n_d;
      net_store_q <= net_store_d;
      net_start_q <= net_start_d;
      net_pixel_q <= net_pixel_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      img_count_q <= img_count_d;
      err_und_q   <= err_und_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign pix_ready    = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign net_rst_n    = net_rst_n_q;
  assign net_store    = net_store_q;
  assign net_start    = net_start_q;
  assign net_pixel    = net_pixel_q;
  assign res_valid    = res_valid_q;
  assign res_class    = res_class_q;
  assign img_count    = img_count_q;
  assign err_underrun = err_und_q;
  assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_gdp_net_seq.sv
// Directed bench for gdp_net_seq with a behavioural core and pixel/class scoreboards.
module tb_gdp_net_seq;
  localparam int N_PIX   = 784;
  localparam int PIX_W   = 16;
  localparam int CLS_W   = 4;
  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 64;
  localparam int FIN_DLY = 3;
  localparam int RUN_DLY = 50;

  logic                    clk = 1'b0;
  logic                    n_reset;
  logic                    pix_valid;
  logic                    pix_ready;
  logic signed [PIX_W-1:0] pix_data;
  logic                    res_valid;
  logic                    res_ready;
  logic        [CLS_W-1:0] res_class;
  logic                    busy;
  logic                    err_underrun;
  logic                    err_timeout;
  logic                    err_clr;
  logic             [15:0] img_count;
  logic                    net_rst_n;
  logic                    net_store;
  logic signed [PIX_W-1:0] net_pixel;
  logic                    core_finish;
  logic                    net_start;
  logic                    core_one_end;
  logic        [CLS_W-1:0] core_cat;

  always #5 clk = ~clk;

  gdp_net_seq #(
    .N_PIX(N_PIX), .PIX_W(PIX_W), .CLS_W(CLS_W), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout), .err_clr(err_clr),
    .img_count(img_count), .net_rst_n(net_rst_n), .net_store(net_store), .net_pixel(net_pixel),
    .net_store_finish(core_finish), .net_start(net_start),
    .net_one_end(core_one_end), .net_categories(core_cat)
  );

  int checks = 0;
  int failures = 0;
  logic signed [PIX_W-1:0] exp_pix[$];
  int exp_cls[$];
  int core_cls = 0;
  bit core_end_en = 1'b1;
  int st_cnt = 0, fin_cnt = 0, run_cnt = 0;
  bit fin_sent = 1'b0, ended = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural core: checks the store burst, then answers finish and one_end.
  always @(negedge clk) begin
    if (!net_rst_n) begin
      st_cnt = 0; fin_cnt = 0; run_cnt = 0;
      fin_sent = 1'b0; ended = 1'b0;
      core_finish = 1'b0; core_one_end = 1'b0;
    end else begin
      core_finish = 1'b0;
      core_one_end = 1'b0;
      if (net_store && st_cnt < N_PIX) begin
        if (exp_pix.size() == 0) check("pix_unexpected", exp_pix.size(), 1);
        else check("net_pixel", net_pixel, exp_pix.pop_front());
        st_cnt++;
      end else if (st_cnt == N_PIX && !fin_sent) begin
        fin_cnt++;
        if (fin_cnt == FIN_DLY) begin
          core_finish = 1'b1;
          fin_sent = 1'b1;
        end
      end
      if (net_start && !ended) begin
        run_cnt++;
        if (run_cnt == RUN_DLY && core_end_en) begin
          core_one_end = 1'b1;
          core_cat = CLS_W'(core_cls);
          ended = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; pix_ready is stable there, so acceptance is known in advance.
  task automatic send_pixels(input int n, input int base);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < n + 20) begin
      pix_valid = 1'b1;
      pix_data = PIX_W'(base + i);
      acc = pix_ready;
      if (acc) exp_pix.push_back(PIX_W'(base + i));
      @(negedge clk);
      guard++;
      if (acc) i++;
    end
    pix_valid = 1'b0;
    check("send_done", i, n);
  endtask

  task automatic get_result(input int bound);
    int n = 0;
    while (!res_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", res_valid, 1);
    if (exp_cls.size() > 0) check("res_class", res_class, exp_cls.pop_front());
    else check("cls_queue", exp_cls.size(), 1);
  endtask

  task automatic handshake(input int exp_cnt);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hs_valid", res_valid, 0);
    check("img_count", img_count, exp_cnt);
    check("rst_lo1", net_rst_n, 0);
    @(negedge clk);
    check("rst_lo2", net_rst_n, 0);
    check("busy_recover", busy, 1);
    @(negedge clk);
    check("rst_hi", net_rst_n, 1);
    check("idle", busy, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int cls3[3];
    cls3[0] = 3; cls3[1] = 9; cls3[2] = 0;
    n_reset = 1'b0; pix_valid = 1'b0; pix_data = '0;
    res_ready = 1'b0; err_clr = 1'b0;
    core_finish = 1'b0; core_one_end = 1'b0; core_cat = '0;

    repeat (3) @(negedge clk);
    check("rst_net_rst_n", net_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_net_store", net_store, 0);
    check("rst_net_start", net_start, 0);
    check("rst_net_pixel", net_pixel, 0);
    check("rst_res_class", res_class, 0);
    check("rst_img_count", img_count, 0);
    check("rst_errs", {err_underrun, err_timeout}, 0);
    n_reset = 1'b1;
    @(negedge clk);
    check("rel_net_rst_n", net_rst_n, 1);

    // Nominal image
    core_cls = 7; exp_cls.push_back(7);
    send_pixels(N_PIX, 0);
    get_result(200);
    check("nom_count_pre", img_count, 0);
    handshake(1);
    check("nom_pix_drained", exp_pix.size(), 0);
    check("nom_errs", {err_underrun, err_timeout}, 0);

    // Result back-pressure
    core_cls = 5; exp_cls.push_back(5);
    send_pixels(N_PIX, 1000);
    get_result(200);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_class === 4'd5 && net_rst_n === 1'b1 && busy === 1'b1)) ok = 1'b0;
    end
    check("bp_stable", ok, 1);
    handshake(2);

    // Underrun after pixel 100
    send_pixels(101, 0);
    @(negedge clk);
    check("und_flag", err_underrun, 1);
    check("und_store", net_store, 0);
    check("und_rst", net_rst_n, 0);
    repeat (2) @(negedge clk);
    check("und_idle", busy, 0);
    check("und_no_res", res_valid, 0);
    check("und_count", img_count, 2);
    check("und_pix_drained", exp_pix.size(), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("und_clr", err_underrun, 0);

    // Core never ends: timeout after 64 RUN cycles
    core_end_en = 1'b0;
    send_pixels(N_PIX, 0);
    begin
      int n = 0;
      while (!net_start && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("tmo_start_seen", net_start, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("tmo_not_yet", err_timeout, 0);
    check("tmo_start_held", net_start, 1);
    @(negedge clk);
    check("tmo_flag", err_timeout, 1);
    check("tmo_start_drop", net_start, 0);
    check("tmo_rst", net_rst_n, 0);
    repeat (2) @(negedge clk);
    check("tmo_idle", busy, 0);
    check("tmo_count", img_count, 2);
    check("tmo_no_res", res_valid, 0);
    core_end_en = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_clr", err_timeout, 0);

    // Back-to-back images with res_ready held high
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      core_cls = cls3[k]; exp_cls.push_back(cls3[k]);
      send_pixels(N_PIX, 100 * k - 200);
      get_result(200);
      wait_idle(20);
    end
    res_ready = 1'b0;
    check("b2b_count", img_count, 5);
    check("b2b_cls_drained", exp_cls.size(), 0);

    // Reset in the middle of LOAD at pixel 400
    send_pixels(400, 0);
    n_reset = 1'b0;
    #1;
    check("mid_rst_net_rst_n", net_rst_n, 0);
    check("mid_rst_store", net_store, 0);
    check("mid_rst_pixel", net_pixel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", pix_ready, 0);
    check("mid_rst_count", img_count, 0);
    @(negedge clk);
    exp_pix.delete();
    n_reset = 1'b1;
    @(negedge clk);
    check("mid_rel_net_rst_n", net_rst_n, 1);
    core_cls = 2; exp_cls.push_back(2);
    send_pixels(N_PIX, 0);
    get_result(200);
    handshake(1);
    check("final_pix_drained", exp_pix.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
